// File: rtl/job_pkg.sv
// ============================================================================
//  job_pkg : shared job channel mode type and helpers
//  Revision: 1.0
// ============================================================================
`default_nettype none

package job_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_START = 2'd1,
      MODE_RUN   = 2'd2,
      MODE_DONE  = 2'd3
   } mode_t;

   function automatic logic is_active(input mode_t m);
      return (m == MODE_START) || (m == MODE_RUN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/job_chan.sv
// ============================================================================
//  job_chan : single job channel, IDLE -> START -> RUN -> DONE with run counter
//  Revision: 1.0
// ============================================================================
`default_nettype none

module job_chan
   import job_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          ack,
   input  logic          abort,
   output mode_t         mode
);

   mode_t         r_mode;
   mode_t         w_mode_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_mode_nxt = r_mode;
      w_cnt_nxt  = r_cnt;
      case (r_mode)
         MODE_IDLE: begin
            if (start) begin
               w_mode_nxt = MODE_START;
               w_cnt_nxt  = len;
            end
         end
         MODE_START: begin
            if (abort) begin
               w_mode_nxt = MODE_IDLE;
               w_cnt_nxt  = '0;
            end else if (r_cnt == '0) begin
               w_mode_nxt = MODE_DONE;
            end else begin
               w_mode_nxt = MODE_RUN;
            end
         end
         MODE_RUN: begin
            // The counter still holds len on the first RUN cycle, so RUN spans len cycles.
            if (abort) begin
               w_mode_nxt = MODE_IDLE;
               w_cnt_nxt  = '0;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  w_mode_nxt = MODE_DONE;
               end
            end
         end
         MODE_DONE: begin
            if (ack) begin
               w_mode_nxt = MODE_IDLE;
            end
         end
         default: begin
            w_mode_nxt = MODE_IDLE;
            w_cnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_IDLE;
         r_cnt  <= '0;
      end else begin
         r_mode <= w_mode_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign mode = r_mode;

endmodule

`default_nettype wire

// File: rtl/job_mode_ctrl.sv
// ============================================================================
//  job_mode_ctrl : NCH independent job channels with busy/active reduction
//  Optional saturating done_cnt output enabled by JOB_CTRL_DONECNT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module job_mode_ctrl
   import job_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NCH-1:0]             start,
   input  logic [NCH*CW-1:0]          len,
   input  logic [NCH-1:0]             ack,
   input  logic [NCH-1:0]             abort,
   output mode_t [NCH-1:0]            mode,
   output logic                       busy,
`ifdef JOB_CTRL_DONECNT_EN
   output logic [$clog2(NCH+1)-1:0]   active_cnt,
   output logic [CW-1:0]              done_cnt
`else
   output logic [$clog2(NCH+1)-1:0]   active_cnt
`endif
);

   localparam int AW = $clog2(NCH + 1);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         job_chan #(
            .CW (CW)
         ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .start (start[gi]),
            .len   (len[gi*CW +: CW]),
            .ack   (ack[gi]),
            .abort (abort[gi]),
            .mode  (mode[gi])
         );
      end
   endgenerate

   logic [AW-1:0] w_active;

   always_comb begin
      w_active = '0;
      for (int i = 0; i < NCH; i++) begin
         if (is_active(mode[i])) begin
            w_active = w_active + AW'(1);
         end
      end
   end

   assign active_cnt = w_active;
   assign busy       = (w_active != '0);

`ifdef JOB_CTRL_DONECNT_EN
   localparam int SW = CW + AW;

   logic [NCH-1:0] r_was_done;
   logic [CW-1:0]  r_done_cnt;
   logic [AW-1:0]  w_new_done;
   logic [SW-1:0]  w_sum;

   // A DONE entry is counted on the edge after it first shows on mode.
   always_comb begin
      w_new_done = '0;
      for (int i = 0; i < NCH; i++) begin
         if ((mode[i] == MODE_DONE) && !r_was_done[i]) begin
            w_new_done = w_new_done + AW'(1);
         end
      end
      w_sum = SW'(r_done_cnt) + SW'(w_new_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_was_done <= '0;
         r_done_cnt <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_was_done[i] <= (mode[i] == MODE_DONE);
         end
         if (w_sum > {{AW{1'b0}}, {CW{1'b1}}}) begin
            r_done_cnt <= {CW{1'b1}};
         end else begin
            r_done_cnt <= w_sum[CW-1:0];
         end
      end
   end

   assign done_cnt = r_done_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_job_mode_ctrl.sv
// ============================================================================
//  tb_job_mode_ctrl : directed scoreboard bench for job_mode_ctrl
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_job_mode_ctrl;
   import job_pkg::*;

   localparam int ID = 0;
   localparam int ST = 1;
   localparam int RN = 2;
   localparam int DN = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      start;
   logic [31:0]     len;
   logic [3:0]      ack;
   logic [3:0]      abort;
   mode_t [3:0]     mode;
   logic            busy;
   logic [2:0]      active_cnt;
`ifdef JOB_CTRL_DONECNT_EN
   logic [7:0]      done_cnt;
   logic            s_start;
   logic [1:0]      s_len;
   logic            s_ack;
   logic            s_abort;
   mode_t [0:0]     s_mode;
   logic            s_busy;
   logic [0:0]      s_active;
   logic [1:0]      s_done;
`endif

   always #5 clk = ~clk;

   job_mode_ctrl #(
      .NCH (4),
      .CW  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .ack        (ack),
      .abort      (abort),
      .mode       (mode),
      .busy       (busy),
`ifdef JOB_CTRL_DONECNT_EN
      .active_cnt (active_cnt),
      .done_cnt   (done_cnt)
`else
      .active_cnt (active_cnt)
`endif
   );

`ifdef JOB_CTRL_DONECNT_EN
   job_mode_ctrl #(
      .NCH (1),
      .CW  (2)
   ) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .start      (s_start),
      .len        (s_len),
      .ack        (s_ack),
      .abort      (s_abort),
      .mode       (s_mode),
      .busy       (s_busy),
      .active_cnt (s_active),
      .done_cnt   (s_done)
   );
`endif

   typedef struct {
      string tag;
      int    kind;
      int    ch;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic push(input string tag, input int kind, input int ch, input int val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.ch   = ch;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic exp_all(input string tag, input int m0, input int m1, input int m2,
                          input int m3, input int b, input int a);
      push(tag, 0, 0, m0);
      push(tag, 0, 1, m1);
      push(tag, 0, 2, m2);
      push(tag, 0, 3, m3);
      push(tag, 1, 0, b);
      push(tag, 2, 0, a);
   endtask

   function automatic logic [31:0] observe(input int kind, input int ch);
      case (kind)
         0: return {30'b0, mode[ch]};
         1: return {31'b0, busy};
         2: return {29'b0, active_cnt};
`ifdef JOB_CTRL_DONECNT_EN
         3: return {24'b0, done_cnt};
         4: return {30'b0, s_done};
         5: return {30'b0, s_mode[0]};
`endif
         default: return '1;
      endcase
   endfunction

   task automatic tick();
      exp_t        e;
      logic [31:0] obs;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.kind, e.ch);
         tests++;
         assert (obs === 32'(e.val)) else begin
            fails++;
            $error("FAIL %s kind=%0d ch=%0d: observed %0d expected %0d",
                   e.tag, e.kind, e.ch, obs, e.val);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = '0; len = '0; ack = '0; abort = '0;
`ifdef JOB_CTRL_DONECNT_EN
      s_start = 1'b0; s_len = '0; s_ack = 1'b0; s_abort = 1'b0;
`endif
      tick();
      exp_all("reset", ID, ID, ID, ID, 0, 0);
`ifdef JOB_CTRL_DONECNT_EN
      push("reset_dcnt", 3, 0, 0);
      push("reset_sat", 4, 0, 0);
`endif
      tick();
      rst = 1'b0;

      // channel 0, len=3; ack in RUN and abort in DONE are ignored
      len[7:0] = 8'd3; start[0] = 1'b1;
      exp_all("t1_start", ST, ID, ID, ID, 1, 1); tick();
      start[0] = 1'b0; len[7:0] = 8'd9;
      exp_all("t1_run2", RN, ID, ID, ID, 1, 1); tick();
      ack[0] = 1'b1;
      exp_all("t1_run3", RN, ID, ID, ID, 1, 1); tick();
      ack[0] = 1'b0;
      exp_all("t1_run4", RN, ID, ID, ID, 1, 1); tick();
      exp_all("t1_done5", DN, ID, ID, ID, 0, 0); tick();
      abort[0] = 1'b1;
      exp_all("t1_done6", DN, ID, ID, ID, 0, 0); tick();
      abort[0] = 1'b0;
`ifdef JOB_CTRL_DONECNT_EN
      push("t1_dcnt", 3, 0, 1);
`endif
      exp_all("t1_done7", DN, ID, ID, ID, 0, 0); tick();
      ack[0] = 1'b1;
      exp_all("t1_idle8", ID, ID, ID, ID, 0, 0); tick();
      ack[0] = 1'b0;

      // channel 1, len=0, start held high through DONE and ack
      len[15:8] = 8'd0; start[1] = 1'b1;
      exp_all("t2_start", ID, ST, ID, ID, 1, 1); tick();
      exp_all("t2_done", ID, DN, ID, ID, 0, 0); tick();
      exp_all("t2_hold", ID, DN, ID, ID, 0, 0); tick();
      ack[1] = 1'b1;
      exp_all("t2_ack", ID, ID, ID, ID, 0, 0); tick();
      ack[1] = 1'b0;
      exp_all("t2_restart", ID, ST, ID, ID, 1, 1); tick();
      start[1] = 1'b0;
      exp_all("t2_done2", ID, DN, ID, ID, 0, 0); tick();
      ack[1] = 1'b1;
`ifdef JOB_CTRL_DONECNT_EN
      push("t2_dcnt", 3, 0, 3);
`endif
      exp_all("t2_idle", ID, ID, ID, ID, 0, 0); tick();
      ack[1] = 1'b0;

      // all four channels, len=5
      len = {4{8'd5}}; start = 4'hF;
      exp_all("t3_start", ST, ST, ST, ST, 1, 4); tick();
      start = 4'h0;
      for (int k = 0; k < 5; k++) begin
         exp_all("t3_run", RN, RN, RN, RN, 1, 4); tick();
      end
`ifdef JOB_CTRL_DONECNT_EN
      push("t3_dcnt_pre", 3, 0, 3);
`endif
      exp_all("t3_done", DN, DN, DN, DN, 0, 0); tick();
`ifdef JOB_CTRL_DONECNT_EN
      push("t3_dcnt_step", 3, 0, 7);
`endif
      exp_all("t3_hold", DN, DN, DN, DN, 0, 0); tick();
      ack = 4'hF;
      exp_all("t3_idle", ID, ID, ID, ID, 0, 0); tick();
      ack = 4'h0;

      // abort ch2 in RUN, abort ch1 in IDLE ignored, then reset mid-RUN on ch0
      len = '0; len[7:0] = 8'd10; len[23:16] = 8'd10; start = 4'b0101;
      exp_all("t4_start", ST, ID, ST, ID, 1, 2); tick();
      start = 4'h0;
      exp_all("t4_run2", RN, ID, RN, ID, 1, 2); tick();
      exp_all("t4_run3", RN, ID, RN, ID, 1, 2); tick();
      abort[2] = 1'b1; abort[1] = 1'b1;
      exp_all("t4_abort", RN, ID, ID, ID, 1, 1); tick();
      abort = 4'h0;
`ifdef JOB_CTRL_DONECNT_EN
      push("t4_dcnt", 3, 0, 7);
`endif
      exp_all("t4_after_abort", RN, ID, ID, ID, 1, 1); tick();
      rst = 1'b1;
`ifdef JOB_CTRL_DONECNT_EN
      push("t4_rst_dcnt", 3, 0, 0);
`endif
      exp_all("t4_rst", ID, ID, ID, ID, 0, 0); tick();
      rst = 1'b0;
      exp_all("t4_post_rst", ID, ID, ID, ID, 0, 0); tick();

`ifdef JOB_CTRL_DONECNT_EN
      // CW=2 instance: five sequential len=1 jobs saturate done_cnt at 3
      for (int j = 1; j <= 5; j++) begin
         s_len = 2'd1; s_start = 1'b1;
         push("sat_start", 5, 0, ST); tick();
         s_start = 1'b0;
         push("sat_run", 5, 0, RN); tick();
         push("sat_done", 5, 0, DN); tick();
         s_ack = 1'b1;
         push("sat_idle", 5, 0, ID);
         push("sat_cnt", 4, 0, (j < 3) ? j : 3);
         tick();
         s_ack = 1'b0;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/job_mode_ctrl.md
# job_mode_ctrl

Multi-channel job sequencer that drives a package-defined mode type per channel through IDLE → START → RUN → DONE. Each channel accepts a start request with a programmable run length, counts it down, and holds DONE until acknowledged; channels can be aborted individually. It sits between a command source issuing per-channel start/len and consumers that observe `mode` and `busy`. This block generalises the single two-value start/done mode port to NCH channels with a 4-state mode, a length counter and a handshake.

## Interface
Parameters:
- NCH, 4, number of independent channels (≥1)
- CW, 8, width of run-length counter and of done_cnt

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset: synchronous, active-high
- start  input  NCH  per-channel start request, sampled only in IDLE
- len  input  NCH×CW  per-channel run length, latched on accepted start
- ack  input  NCH  per-channel acknowledge, effective only in DONE
- abort  input  NCH  per-channel abort, effective in START/RUN
- mode  output  NCH×mode_t (2 b each)  current channel state
- busy  output  1  OR over channels in START or RUN
- active_cnt  output  $clog2(NCH+1)  count of channels in START or RUN
- done_cnt  output  CW  saturating completed-job count (only with JOB_CTRL_DONECNT_EN)

## Operation
- mode_t states: IDLE=0, START=1, RUN=2, DONE=3.
- IDLE: start[i]=1 → START; len[i] latched into channel counter. Otherwise stay.
- START (exactly one cycle): counter==0 → DONE; else → RUN.
- RUN: counter decrements each cycle; when counter==1 → DONE next cycle. RUN lasts exactly len cycles.
- DONE: hold until ack[i]=1 → IDLE. start ignored in DONE, including same cycle as ack (no chaining).
- abort[i] in START or RUN → IDLE next cycle, counter cleared; highest priority. abort in IDLE/DONE ignored.
- start in START/RUN/DONE ignored; ack outside DONE ignored; len changes after latch have no effect.
- Channels fully independent; no arbitration.
- busy and active_cnt are combinational from registered state.

## Timing
- rst=1 at a clock edge: all mode=IDLE, counters=0, busy=0, active_cnt=0, done_cnt=0. Reset mid-job discards job, no DONE issued.
- start at edge 0 (len=L≥1): mode=START after edge 1 window, RUN cycles 2..L+1, DONE from cycle L+2.
- len=0: START at cycle 1, DONE at cycle 2.
- ack at cycle k in DONE → IDLE at k+1; a new start earliest accepted at k+1 → START at k+2.
- active_cnt never exceeds NCH; width sized to hold NCH.

## Configuration
- JOB_CTRL_DONECNT_EN defined: done_cnt port present; increments by the number of channels transitioning into DONE that cycle (0..NCH), saturating at 2^CW−1; cleared only by rst.
- Undefined: done_cnt port and its logic absent; all other behaviour identical.

## Structure
- Package job_pkg: mode_t enum (logic [1:0]), state encodings above; imported in the module header so ports may use mode_t.
- Sub-module job_chan: single-channel FSM + CW-bit counter (ports clk, rst, start, len, ack, abort, mode), instantiated NCH times via generate. Top holds busy/active_cnt reduction and optional done_cnt.

## Test plan
- Reset then idle: rst 2 cycles → all mode=IDLE, busy=0, active_cnt=0, done_cnt=0.
- Ch0 start with len=3 → START at cycle 1, RUN cycles 2–4, DONE cycle 5; ack cycle 7 → IDLE cycle 8.
- len=0 on ch1 → START cycle 1, DONE cycle 2; start held high in DONE → stays DONE until ack.
- All 4 channels start same cycle, len=5 → active_cnt=4 for cycles 1–6, all DONE cycle 7; done_cnt +4 in one step (macro on).
- Abort ch2 in RUN at cycle 3 (len=10) → IDLE cycle 4, no DONE, done_cnt unchanged; rst asserted mid-RUN on ch0 → IDLE next cycle.
- CW=2, macro on: 5 sequential jobs → done_cnt saturates at 3.
